// File: rtl/mem_bus_defines.sv
// -----------------------------------------------------------------------------
// mem_bus_defines
//   Shared definitions for the MEM-stage data bus.
//   - MA_* : bit positions inside the memory-access control field (rw, en).
//   - DBUSO: initiator-to-responder bundle, packed as {addr, wdata, ma}.
//   - DBUSI: responder-to-initiator bundle, packed as {miss, rdata}.
//   - dbi_state_e: state encoding of the data-bus initiator.
//   The field helpers take the data width because the bundles are sized by
//   the instantiating module's parameters.
// -----------------------------------------------------------------------------
package mem_bus_defines;

  localparam int MA_RW    = 0;
  localparam int MA_EN    = 1;
  localparam int MA_WIDTH = 2;

  // DBUSO = {addr, wdata, ma}
  localparam int DBUSO_MA_LSB    = 0;
  localparam int DBUSO_WDATA_LSB = MA_WIDTH;

  function automatic int dbuso_addr_lsb(input int data_width);
    return MA_WIDTH + data_width;
  endfunction

  function automatic int dbuso_width(input int addr_width, input int data_width);
    return addr_width + data_width + MA_WIDTH;
  endfunction

  // DBUSI = {miss, rdata}
  localparam int DBUSI_RDATA_LSB = 0;

  function automatic int dbusi_miss_pos(input int data_width);
    return data_width;
  endfunction

  typedef enum logic [1:0] {
    DBI_IDLE   = 2'd0,
    DBI_ACCESS = 2'd1,
    DBI_RESP   = 2'd2
  } dbi_state_e;

endpackage

// File: rtl/dbus_sat_counter.sv
// -----------------------------------------------------------------------------
// dbus_sat_counter
//   Free-running event counter that sticks at all-ones instead of wrapping.
//   Ports:
//     Clk   - clock, rising edge
//     Rst   - asynchronous active-low reset, clears the count
//     inc   - count one event this cycle
//     count - current count
// -----------------------------------------------------------------------------
module dbus_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/dbus_initiator.sv
// -----------------------------------------------------------------------------
// dbus_initiator
//   MEM-stage data-bus initiator. Takes one load/store request from the
//   pipeline, drives it onto the data bus until the responder stops signalling
//   miss (or a miss timeout expires), stalls the pipeline meanwhile and hands
//   back a one-cycle response with the load data.
//
//   Optional feature: define DBUS_INITIATOR_STATS_EN to build the access and
//   miss-cycle statistics counters; otherwise stat_* are tied to 0.
//
//   Ports:
//     Clk, Rst           clock / asynchronous active-low reset
//     req_valid/rw/addr/wdata   pipeline request (held while stall_o=1)
//     stall_o            freeze pipeline
//     rsp_valid          one-cycle completion pulse
//     rsp_rdata          load data (held until the next load completes)
//     rsp_err            with rsp_valid: aborted by miss timeout
//     bus_addr/wdata/rw/en      registered bus drive, all 0 while idle
//     bus_rdata, bus_miss       responder return path
//     stat_access, stat_miss    completed accesses / miss cycles
// -----------------------------------------------------------------------------
module dbus_initiator
  import mem_bus_defines::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MISS_TIMEOUT = 255
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  req_valid,
  input  logic                  req_rw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall_o,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_rw,
  output logic                  bus_en,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_miss,
  output logic [31:0]           stat_access,
  output logic [31:0]           stat_miss
);

  localparam int DBUSO_W  = dbuso_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int ADDR_LSB = dbuso_addr_lsb(DATA_WIDTH);
  localparam int MISS_POS = dbusi_miss_pos(DATA_WIDTH);
  localparam int MCW      = (MISS_TIMEOUT < 1) ? 1 : $clog2(MISS_TIMEOUT + 1);
  // Value of the miss counter on the last permitted miss cycle.
  localparam logic [MCW-1:0] MISS_LAST = (MISS_TIMEOUT < 1) ? '0 : MCW'(MISS_TIMEOUT - 1);

  dbi_state_e            state_reg, state_next;
  // The bus drive register doubles as the latched request: it is loaded once
  // in IDLE and cleared on leaving ACCESS, so bus fields read 0 when idle.
  logic [DBUSO_W-1:0]    dbuso_reg, dbuso_next;
  logic [MCW-1:0]        miss_cnt_reg, miss_cnt_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic                  rsp_err_reg, rsp_err_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic                  stall_next;

  logic [DATA_WIDTH:0]   dbusi;
  logic                  miss_in;
  logic                  timeout_hit;
  logic                  access_miss;

  assign dbusi       = {bus_miss, bus_rdata};
  assign miss_in     = dbusi[MISS_POS];
  assign timeout_hit = (MISS_TIMEOUT != 0) && (miss_cnt_reg == MISS_LAST);
  assign access_miss = (state_reg == DBI_ACCESS) && miss_in;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg     <= DBI_IDLE;
      dbuso_reg     <= '0;
      miss_cnt_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      dbuso_reg     <= dbuso_next;
      miss_cnt_reg  <= miss_cnt_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    dbuso_next     = dbuso_reg;
    miss_cnt_next  = miss_cnt_reg;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
    stall_next     = 1'b0;

    case (state_reg)
      DBI_IDLE: begin
        stall_next = req_valid;
        if (req_valid) begin
          state_next                                    = DBI_ACCESS;
          miss_cnt_next                                 = '0;
          dbuso_next                                    = '0;
          dbuso_next[ADDR_LSB +: ADDR_WIDTH]            = req_addr;
          dbuso_next[DBUSO_WDATA_LSB +: DATA_WIDTH]     = req_wdata;
          dbuso_next[DBUSO_MA_LSB + MA_RW]              = req_rw;
          dbuso_next[DBUSO_MA_LSB + MA_EN]              = 1'b1;
        end
      end

      DBI_ACCESS: begin
        stall_next = 1'b1;
        if (!miss_in) begin
          state_next     = DBI_RESP;
          rsp_valid_next = 1'b1;
          dbuso_next     = '0;
          if (!dbuso_reg[DBUSO_MA_LSB + MA_RW]) begin
            rsp_rdata_next = dbusi[DBUSI_RDATA_LSB +: DATA_WIDTH];
          end
        end else begin
          if (miss_cnt_reg != '1) begin
            miss_cnt_next = miss_cnt_reg + MCW'(1);
          end
          if (timeout_hit) begin
            state_next     = DBI_RESP;
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            dbuso_next     = '0;
          end
        end
      end

      DBI_RESP: begin
        state_next = DBI_IDLE;
      end

      default: begin
        state_next = DBI_IDLE;
        dbuso_next = '0;
      end
    endcase
  end

  // stall_o is combinational in IDLE; gate it with reset so it drops
  // together with the registered outputs when reset is asserted.
  assign stall_o   = stall_next & Rst;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign bus_addr  = dbuso_reg[ADDR_LSB +: ADDR_WIDTH];
  assign bus_wdata = dbuso_reg[DBUSO_WDATA_LSB +: DATA_WIDTH];
  assign bus_rw    = dbuso_reg[DBUSO_MA_LSB + MA_RW];
  assign bus_en    = dbuso_reg[DBUSO_MA_LSB + MA_EN];

`ifdef DBUS_INITIATOR_STATS_EN
  dbus_sat_counter #(.WIDTH(32)) u_stat_access (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (rsp_valid_reg),
    .count (stat_access)
  );

  dbus_sat_counter #(.WIDTH(32)) u_stat_miss (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (access_miss),
    .count (stat_miss)
  );
`else
  logic unused_stats;
  assign unused_stats = access_miss;
  assign stat_access  = '0;
  assign stat_miss    = '0;
`endif

endmodule

// File: tb/tb_dbus_initiator.sv
`timescale 1ns/1ps
module tb_dbus_initiator;

  localparam int TMO  = 4;
  localparam int NCYC = 60;

`ifdef DBUS_INITIATOR_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        Clk, Rst;
  logic        req_valid, req_rw, bus_miss;
  logic [31:0] req_addr, req_wdata, bus_rdata;
  logic        stall_o, rsp_valid, rsp_err, bus_rw, bus_en;
  logic [31:0] rsp_rdata, bus_addr, bus_wdata, stat_access, stat_miss;

  dbus_initiator #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .MISS_TIMEOUT (TMO)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .req_valid   (req_valid),
    .req_rw      (req_rw),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall_o     (stall_o),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rw      (bus_rw),
    .bus_en      (bus_en),
    .bus_rdata   (bus_rdata),
    .bus_miss    (bus_miss),
    .stat_access (stat_access),
    .stat_miss   (stat_miss)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  // Stimulus timeline (per cycle)
  bit          s_req_valid [NCYC];
  bit          s_req_rw    [NCYC];
  logic [31:0] s_req_addr  [NCYC];
  logic [31:0] s_req_wdata [NCYC];
  bit          s_miss      [NCYC];
  logic [31:0] s_rdata     [NCYC];

  // Expected timeline, derived from transaction-level rules
  bit          e_stall [NCYC];
  bit          e_en    [NCYC];
  bit          e_rw    [NCYC];
  logic [31:0] e_addr  [NCYC];
  logic [31:0] e_wdata [NCYC];
  bit          e_rsp   [NCYC];
  bit          e_err   [NCYC];
  bit          rd_upd  [NCYC];
  logic [31:0] rd_val  [NCYC];

  logic [31:0] cur_rd;
  int          exp_acc, exp_miss;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One access: request presented at t0, nmiss responder miss cycles.
  // An access holds the bus for nmiss+1 cycles, or TMO cycles when it times out.
  task automatic plan(input int t0, input bit rw, input logic [31:0] addr,
                      input logic [31:0] wdata, input int nmiss, input logic [31:0] rdata,
                      input bit hold_resp, input bit wiggle);
    bit tmo;
    int k;
    tmo = (TMO != 0) && (nmiss >= TMO);
    k   = tmo ? TMO : nmiss + 1;
    for (int c = t0; c <= t0 + k; c++) begin
      s_req_valid[c] = 1'b1;
      s_req_rw[c]    = rw;
      s_req_addr[c]  = (wiggle && c > t0) ? ~addr  : addr;
      s_req_wdata[c] = (wiggle && c > t0) ? ~wdata : wdata;
      e_stall[c]     = 1'b1;
    end
    for (int c = t0 + 1; c <= t0 + k; c++) begin
      e_en[c]    = 1'b1;
      e_rw[c]    = rw;
      e_addr[c]  = addr;
      e_wdata[c] = wdata;
      s_miss[c]  = ((c - t0) <= nmiss);
    end
    if (!tmo) s_rdata[t0 + k] = rdata;
    e_rsp[t0 + k + 1] = 1'b1;
    e_err[t0 + k + 1] = tmo;
    if (!tmo && !rw) begin
      rd_upd[t0 + k + 1] = 1'b1;
      rd_val[t0 + k + 1] = rdata;
    end
    if (hold_resp) begin
      s_req_valid[t0 + k + 1] = 1'b1;
      s_req_rw[t0 + k + 1]    = rw;
      s_req_addr[t0 + k + 1]  = addr;
      s_req_wdata[t0 + k + 1] = wdata;
    end
  endtask

  task automatic check_cycle(input int c);
    string p;
    p = $sformatf("c%0d", c);
    if (rd_upd[c]) cur_rd = rd_val[c];
    chk({p, " stall_o"},   {31'd0, stall_o},   {31'd0, e_stall[c]});
    chk({p, " bus_en"},    {31'd0, bus_en},    {31'd0, e_en[c]});
    chk({p, " bus_rw"},    {31'd0, bus_rw},    e_en[c] ? {31'd0, e_rw[c]} : 32'd0);
    chk({p, " bus_addr"},  bus_addr,           e_en[c] ? e_addr[c]  : 32'd0);
    chk({p, " bus_wdata"}, bus_wdata,          e_en[c] ? e_wdata[c] : 32'd0);
    chk({p, " rsp_valid"}, {31'd0, rsp_valid}, {31'd0, e_rsp[c]});
    if (e_rsp[c]) chk({p, " rsp_err"}, {31'd0, rsp_err}, {31'd0, e_err[c]});
    chk({p, " rsp_rdata"}, rsp_rdata,          cur_rd);
    chk({p, " stat_access"}, stat_access,      STATS_ON ? 32'(exp_acc)  : 32'd0);
    chk({p, " stat_miss"},   stat_miss,        STATS_ON ? 32'(exp_miss) : 32'd0);
    if (e_rsp[c])
      $display("txn done cycle %0d: err=%0b rdata=%h", c, rsp_err, rsp_rdata);
    if (e_rsp[c]) exp_acc++;
    if (e_en[c] && s_miss[c]) exp_miss++;

    // Hand-computed anchors
    if (c == 3) begin
      chk("lit load bus_en", {31'd0, bus_en}, 32'd1);
      chk("lit load addr", bus_addr, 32'h0000_0010);
    end
    if (c == 4) begin
      chk("lit load rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("lit load rdata", rsp_rdata, 32'hDEAD_BEEF);
    end
    if (c == 5) chk("lit load rsp pulse", {31'd0, rsp_valid}, 32'd0);
    if (c == 9) begin
      chk("lit store rw", {31'd0, bus_rw}, 32'd1);
      chk("lit store wdata", bus_wdata, 32'h1234_5678);
    end
    if (c == 11) chk("lit store stall", {31'd0, stall_o}, 32'd1);
    if (c == 12) chk("lit store rsp_valid", {31'd0, rsp_valid}, 32'd1);
    if (c == 20) begin
      chk("lit timeout err", {31'd0, rsp_err}, 32'd1);
      chk("lit timeout rdata kept", rsp_rdata, 32'hDEAD_BEEF);
    end
    if (c == 25 || c == 28) chk("lit b2b rsp_valid", {31'd0, rsp_valid}, 32'd1);
    if (c == 47) chk("lit edge hit rdata", rsp_rdata, 32'h3333_4444);
    if (c == 56) begin
      chk("lit stat_access", stat_access, STATS_ON ? 32'd9 : 32'd0);
      chk("lit stat_miss", stat_miss, STATS_ON ? 32'd17 : 32'd0);
    end
  endtask

  initial begin
    Rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
    bus_miss = 1'b0; bus_rdata = '0;

    for (int c = 0; c < NCYC; c++) begin
      s_req_valid[c] = 1'b0; s_req_rw[c] = 1'b0; s_req_addr[c] = '0; s_req_wdata[c] = '0;
      s_miss[c] = 1'b0; s_rdata[c] = 32'hBAD0_0000 + 32'(c);
      e_stall[c] = 1'b0; e_en[c] = 1'b0; e_rw[c] = 1'b0; e_addr[c] = '0; e_wdata[c] = '0;
      e_rsp[c] = 1'b0; e_err[c] = 1'b0; rd_upd[c] = 1'b0; rd_val[c] = '0;
    end

    plan( 2, 1'b0, 32'h0000_0010, 32'h0000_0000, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    plan( 7, 1'b1, 32'h0000_0020, 32'h1234_5678, 3, 32'h0,         1'b0, 1'b0);
    plan(15, 1'b0, 32'h0000_0030, 32'h0000_0000, 5, 32'h5555_AAAA, 1'b0, 1'b0);
    plan(23, 1'b0, 32'h0000_0040, 32'h0000_0000, 0, 32'hA5A5_0001, 1'b1, 1'b0);
    plan(26, 1'b0, 32'h0000_0044, 32'h0000_0000, 0, 32'h0000_0002, 1'b0, 1'b0);
    plan(31, 1'b0, 32'h0000_0050, 32'h0000_0000, 1, 32'h1111_2222, 1'b0, 1'b0);
    plan(36, 1'b1, 32'h0000_0054, 32'hCAFE_F00D, 2, 32'h0,         1'b0, 1'b1);
    plan(42, 1'b0, 32'h0000_0058, 32'h0000_0000, 3, 32'h3333_4444, 1'b0, 1'b0);
    plan(49, 1'b1, 32'h0000_0060, 32'h9999_8888, 4, 32'h0,         1'b0, 1'b0);
    // Responder miss outside ACCESS must not affect anything
    s_miss[12] = 1'b1;
    s_miss[13] = 1'b1;

    // Reset state
    #1 Rst = 1'b0;
    #1;
    chk("rst stall_o",   {31'd0, stall_o},   32'd0);
    chk("rst bus_en",    {31'd0, bus_en},    32'd0);
    chk("rst bus_rw",    {31'd0, bus_rw},    32'd0);
    chk("rst bus_addr",  bus_addr,           32'd0);
    chk("rst bus_wdata", bus_wdata,          32'd0);
    chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst rsp_err",   {31'd0, rsp_err},   32'd0);
    chk("rst rsp_rdata", rsp_rdata,          32'd0);
    chk("rst stat_access", stat_access,      32'd0);
    chk("rst stat_miss",   stat_miss,        32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Rst = 1'b1;

    cur_rd = '0; exp_acc = 0; exp_miss = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge Clk); #1;
      req_valid = s_req_valid[c];
      req_rw    = s_req_rw[c];
      req_addr  = s_req_addr[c];
      req_wdata = s_req_wdata[c];
      bus_miss  = s_miss[c];
      bus_rdata = s_rdata[c];
      @(negedge Clk);
      check_cycle(c);
    end

    // Reset in the middle of a missing access
    @(posedge Clk); #1;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h0000_0070; req_wdata = '0;
    bus_miss = 1'b1; bus_rdata = 32'h0BAD_0BAD;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("mid bus_en before rst", {31'd0, bus_en}, 32'd1);
    chk("mid stall before rst", {31'd0, stall_o}, 32'd1);
    #2 Rst = 1'b0;
    #1;
    chk("mid rst bus_en",    {31'd0, bus_en},    32'd0);
    chk("mid rst stall_o",   {31'd0, stall_o},   32'd0);
    chk("mid rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid rst bus_addr",  bus_addr,           32'd0);
    chk("mid rst rsp_rdata", rsp_rdata,          32'd0);
    chk("mid rst stat_access", stat_access,      32'd0);
    chk("mid rst stat_miss",   stat_miss,        32'd0);
    $display("txn reset mid-access at %0t", $time);
    req_valid = 1'b0; bus_miss = 1'b0;
    @(negedge Clk) Rst = 1'b1;

    // Fresh load after reset
    @(posedge Clk); #1;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h0000_0074; bus_rdata = 32'h7777_8888;
    @(negedge Clk);
    chk("post stall idle", {31'd0, stall_o}, 32'd1);
    chk("post bus_en idle", {31'd0, bus_en}, 32'd0);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("post bus_en", {31'd0, bus_en}, 32'd1);
    chk("post bus_addr", bus_addr, 32'h0000_0074);
    @(posedge Clk); #1;
    req_valid = 1'b0;
    @(negedge Clk);
    chk("post rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("post rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("post rsp_rdata", rsp_rdata, 32'h7777_8888);
    chk("post stall resp", {31'd0, stall_o}, 32'd0);
    $display("txn post-reset load rdata=%h", rsp_rdata);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("post rsp pulse end", {31'd0, rsp_valid}, 32'd0);
    chk("post stat_access", stat_access, STATS_ON ? 32'd1 : 32'd0);
    chk("post stat_miss", stat_miss, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
